// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry constants and FSM state encoding for the data cache
package dcache_pkg;
    localparam int TAG_W       = 3;
    localparam int INDEX_W     = 3;
    localparam int OFFSET_W    = 2;
    localparam int BLOCKS      = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int LINE_W      = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;
endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays with a byte-write port and a line-fill port
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                byte_we,
    input  logic [7:0]          byte_data,
    input  logic                fill_we,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [LINE_W-1:0]   fill_data,
    output logic                valid,
    output logic                dirty,
    output logic [TAG_W-1:0]    tag,
    output logic [LINE_W-1:0]   data
);
    logic [BLOCKS-1:0] valid_q;
    logic [BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]  tag_q  [BLOCKS];
    logic [LINE_W-1:0] data_q [BLOCKS];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];

    // status bits: cleared by reset, set clean on fill, marked dirty by a store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // payload arrays need no reset; valid gates every use of them
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (byte_we) begin
            data_q[index][{offset, 3'b000} +: 8] <= byte_data;
        end
    end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache with block-wide memory handshake
module data_cache
    import dcache_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       read,
    input  logic                       write,
    input  logic [7:0]                 address,
    input  logic [7:0]                 writedata,
    output logic [7:0]                 readdata,
    output logic                       busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [TAG_W+INDEX_W-1:0]   mem_address,
    output logic [LINE_W-1:0]          mem_writedata,
    input  logic [LINE_W-1:0]          mem_readdata,
    input  logic                       mem_busywait
);
    state_t state, state_next;
    logic seen_busy;
    logic [LINE_W-1:0] fetched;
    logic line_valid, line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic [LINE_W-1:0] line_data;

    wire [TAG_W-1:0]    req_tag    = address[7:5];
    wire [INDEX_W-1:0]  index      = address[4:2];
    wire [OFFSET_W-1:0] offset     = address[1:0];
    wire                req        = read | write;
    wire                hit        = line_valid & (line_tag == req_tag);
    wire                idle_hit   = (state == IDLE) & hit;
    wire                xfer_done  = seen_busy & ~mem_busywait;

    dcache_line_store u_store (
        .clk       (clk),
        .reset     (reset),
        .index     (index),
        .offset    (offset),
        .byte_we   (idle_hit & write),
        .byte_data (writedata),
        .fill_we   (state == UPDATE),
        .fill_tag  (req_tag),
        .fill_data (fetched),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .data      (line_data)
    );

    assign busywait      = req & ~idle_hit;
    assign readdata      = (idle_hit & read & ~write) ? line_data[{offset, 3'b000} +: 8] : 8'h00;
    assign mem_read      = state == FETCH;
    assign mem_write     = state == WRITEBACK;
    assign mem_address   = mem_write ? {line_tag, index} : mem_read ? {req_tag, index} : '0;
    assign mem_writedata = mem_write ? line_data : '0;

    // next state: a miss goes through write-back only when the victim is dirty
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = (req & ~hit) ? (line_dirty ? WRITEBACK : FETCH) : IDLE;
            WRITEBACK: state_next = xfer_done ? FETCH : WRITEBACK;
            FETCH:     state_next = xfer_done ? UPDATE : FETCH;
            UPDATE:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // state, memory-busy tracking per transfer, and capture of the fetched block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
            fetched   <= '0;
        end else begin
            state     <= state_next;
            seen_busy <= (state_next != state) ? 1'b0 : seen_busy | (mem_busywait & (mem_read | mem_write));
            fetched   <= (mem_read & xfer_done) ? mem_readdata : fetched;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed scoreboard bench for data_cache with a behavioural block memory
module tb_data_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [7:0]  writedata = 8'h00;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    localparam int HOLD = 4;
    localparam int CLEAN_MISS = HOLD + 3;
    localparam int DIRTY_MISS = 2 * HOLD + 4;

    logic [31:0] blk [64];
    int cnt;
    int n_reads = 0;
    int n_writes = 0;
    logic [5:0]  last_raddr = '0;
    logic [5:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    data_cache dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clk = ~clk;

    // memory: raises busy in the request's first cycle, holds it HOLD cycles, then completes
    initial begin
        mem_busywait = 1'b0;
        mem_readdata = '0;
        cnt = 0;
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 4; k++)
                blk[i][8*k +: 8] = 8'(i * 4 + k) ^ 8'h80;
        blk[5] = 32'hDDCCBBAA;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_busywait = 1'b0;
                cnt = 0;
            end else if (mem_read || mem_write) begin
                if (!mem_busywait) begin
                    mem_busywait = 1'b1;
                    cnt = HOLD - 1;
                    if (mem_read) begin
                        n_reads++;
                        last_raddr = mem_address;
                    end else begin
                        n_writes++;
                        last_waddr = mem_address;
                        last_wdata = mem_writedata;
                    end
                end else if (cnt != 0) begin
                    cnt--;
                end else begin
                    mem_busywait = 1'b0;
                    if (mem_read) mem_readdata = blk[mem_address];
                    else blk[mem_address] = mem_writedata;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int exp_cyc, input string tag);
        int cyc = 0;
        @(negedge clk);
        read = rd;
        write = wr;
        address = a;
        writedata = wd;
        if (rd) exp_q.push_back(exp_rd);
        #1;
        while (busywait && cyc < 60) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check({tag, " stall cycles"}, cyc, exp_cyc);
        if (rd) check({tag, " readdata"}, {24'h0, readdata}, {24'h0, exp_q.pop_front()});
        @(posedge clk);
        #1;
        read = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        int r0;
        int w;
        repeat (2) @(negedge clk);
        check("reset busywait", busywait, 0);
        check("reset mem_read", mem_read, 0);
        check("reset mem_write", mem_write, 0);
        check("reset mem_address", mem_address, 0);
        check("reset mem_writedata", mem_writedata, 0);
        check("reset readdata", readdata, 0);
        reset = 1'b0;

        do_req(1, 0, 8'h14, 8'h00, 8'hAA, CLEAN_MISS, "rd14 miss");
        check("rd14 fetch addr", last_raddr, 6'h05);
        check("rd14 fetch count", n_reads, 1);

        do_req(1, 0, 8'h17, 8'h00, 8'hDD, 0, "rd17 hit");
        check("rd17 no fetch", n_reads, 1);
        @(negedge clk);
        check("idle readdata", readdata, 0);
        check("idle mem_address", mem_address, 0);

        do_req(0, 1, 8'h15, 8'h5A, 8'h00, 0, "wr15 hit");
        do_req(1, 0, 8'h15, 8'h00, 8'h5A, 0, "rd15 after store");

        do_req(1, 0, 8'h34, 8'h00, 8'hB4, DIRTY_MISS, "rd34 dirty miss");
        check("rd34 wb addr", last_waddr, 6'h05);
        check("rd34 wb data", last_wdata, 32'hDDCC5AAA);
        check("rd34 fetch addr", last_raddr, 6'h0D);
        check("rd34 wb count", n_writes, 1);

        r0 = n_reads;
        @(negedge clk);
        read = 1'b1;
        address = 8'h14;
        w = 0;
        while (!mem_read && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst fetch entered", mem_read, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst mem_read drop", mem_read, 0);
        check("rst mem_write low", mem_write, 0);
        check("rst mem_address", mem_address, 0);
        read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_req(1, 0, 8'h14, 8'h00, 8'hAA, CLEAN_MISS, "rd14 after rst");
        check("rd14 refetch count", n_reads, r0 + 2);

        do_req(0, 1, 8'h02, 8'h77, 8'h00, CLEAN_MISS, "wr02 miss");
        check("wr02 fetch addr", last_raddr, 6'h00);
        do_req(1, 0, 8'h02, 8'h00, 8'h77, 0, "rd02 stored");
        do_req(1, 0, 8'h00, 8'h00, 8'h80, 0, "rd00 filled");
        do_req(1, 0, 8'h22, 8'h00, 8'hA2, DIRTY_MISS, "rd22 evict");
        check("rd22 wb addr", last_waddr, 6'h00);
        check("rd22 wb data", last_wdata, 32'h83778180);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
